cond_logic_pipe: RTL and testbench
==================================

COND_LOGIC_PIPE -- requirements
Module: cond_logic_pipe

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the ports SHALL be named clk and reset.
REQ-002 Parameter NUM_CTX, default 2: number of independent flag contexts, legal range 1..16.
REQ-003 Parameter CNT_W, default 16: width of the skip counter.
REQ-004 Derived parameter CTX_W SHALL equal max(1, clog2(NUM_CTX)).
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 valid_in  in  1  an instruction is presented this cycle.
REQ-008 stall  in  1  hold all state and outputs.
REQ-009 flush  in  1  annul the presented instruction.
REQ-010 ctx  in  CTX_W  flag context selected for this instruction.
REQ-011 cond  in  4  ARM condition field.
REQ-012 alu_flags  in  4  {Z,C,N,V} from the ALU (bit3=Z, bit2=C, bit1=N, bit0=V).
REQ-013 flag_write  in  2  bit1 = update N,Z; bit0 = update C,V.
REQ-014 pcs_in, reg_w_in, mem_w_in, no_write_in  in  1 each  decoder write/PC controls.
REQ-015 valid_out  out  1  registered instruction valid.
REQ-016 cond_ex  out  1  registered condition-passed result.
REQ-017 pcs_out, reg_w_out, mem_w_out  out  1 each  gated controls.
REQ-018 undef_cond  out  1  registered: cond was 4'b1111.
REQ-019 flags_out  out  4  stored {Z,C,N,V} of the context selected by ctx (combinational read).
REQ-020 skip_cnt  out  CNT_W  count of annulled valid instructions.

Function
REQ-021 Condition evaluation SHALL use the stored flags of context ctx: 0000 Z; 0001 ~Z; 0010 C; 0011 ~C; 0100 N; 0101 ~N; 0110 V; 0111 ~V; 1000 C&~Z; 1001 ~C|Z; 1010 N==V; 1011 N!=V; 1100 ~Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 0 with undef_cond=1.
REQ-022 An instruction is accepted when valid_in=1, stall=0, flush=0; outputs SHALL reflect it exactly one cycle later.
REQ-023 On acceptance: pcs_out=pcs_in&pass, reg_w_out=reg_w_in&pass&~no_write_in, mem_w_out=mem_w_in&pass, valid_out=1.
REQ-024 On acceptance with pass=1, flag_write[1] SHALL load N,Z and flag_write[0] SHALL load C,V of context ctx from alu_flags; other contexts and unselected flag pairs SHALL be unchanged.
REQ-025 A flag update at edge k SHALL be visible to an instruction evaluated in cycle k+1 in the same context (no extra bubble).
REQ-026 When no instruction is accepted and stall=0, valid_out, cond_ex, pcs_out, reg_w_out, mem_w_out, undef_cond SHALL be 0 next cycle.
REQ-027 stall=1 and flush=0: all outputs, flags and skip_cnt SHALL hold.
REQ-028 flush=1 SHALL take priority over stall and valid_in: no flag or counter update; outputs cleared next cycle.
REQ-029 ctx >= NUM_CTX SHALL be treated as not passing (cond_ex=0, undef_cond=1) and SHALL NOT update flags.
REQ-030 Accepted instructions with pass=0 SHALL increment skip_cnt; skip_cnt SHALL saturate at all-ones (no wrap).

Reset
REQ-031 reset SHALL asynchronously clear all flags in all contexts, skip_cnt, and all registered outputs to 0.
REQ-032 Reset mid-operation SHALL discard the in-flight instruction; the first post-reset cycle SHALL show valid_out=0.

Configuration
REQ-033 Macro COND_SKIP_COUNT_EN: when defined, skip_cnt SHALL behave per REQ-030; when undefined, the counter SHALL be omitted and skip_cnt tied to 0, port retained.

Verification
REQ-034 After reset, ctx=0, cond=0000, valid_in=1 -> next cycle cond_ex=0, valid_out=1, skip_cnt=1.
REQ-035 Cycle 0: ctx=1, cond=1110, alu_flags=4'b1000, flag_write=2'b11; cycle 1: ctx=1, cond=0000 -> cycle 2 cond_ex=1; same in ctx=0 -> cond_ex=0.
REQ-036 Stored N=1,V=0: cond=1011 -> cond_ex=1; cond=1010 -> cond_ex=0; cond=1101 -> cond_ex=1.
REQ-037 stall=1 for 3 cycles with valid_in=1, reg_w_in=1 -> outputs and flags frozen; then flush=1 with stall=1 -> next cycle valid_out=0, flags unchanged.
REQ-038 cond=1111, reg_w_in=1 -> undef_cond=1, reg_w_out=0; with CNT_W=2 and 5 failing instructions -> skip_cnt=3.
REQ-039 Assert reset while valid_out=1 -> outputs 0 immediately, flags 0 for every context.

Source files
------------

// File: rtl/cond_logic_pipe.sv
// ARM-style conditional-execution stage with per-context {Z,C,N,V} flag banks.
// Optional skip counter enabled by defining COND_SKIP_COUNT_EN.
module cond_logic_pipe #(
  parameter int NUM_CTX = 2,
  parameter int CNT_W   = 16,
  localparam int CTX_W  = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             stall,
  input  logic             flush,
  input  logic [CTX_W-1:0] ctx,
  input  logic [3:0]       cond,
  input  logic [3:0]       alu_flags,
  input  logic [1:0]       flag_write,
  input  logic             pcs_in,
  input  logic             reg_w_in,
  input  logic             mem_w_in,
  input  logic             no_write_in,
  output logic             valid_out,
  output logic             cond_ex,
  output logic             pcs_out,
  output logic             reg_w_out,
  output logic             mem_w_out,
  output logic             undef_cond,
  output logic [3:0]       flags_out,
  output logic [CNT_W-1:0] skip_cnt
);

  // Flag word layout is {Z,C,N,V}.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic z, cy, n, v;
    z  = f[3];
    cy = f[2];
    n  = f[1];
    v  = f[0];
    case (c)
      4'b0000: return z;
      4'b0001: return ~z;
      4'b0010: return cy;
      4'b0011: return ~cy;
      4'b0100: return n;
      4'b0101: return ~n;
      4'b0110: return v;
      4'b0111: return ~v;
      4'b1000: return cy & ~z;
      4'b1001: return ~cy | z;
      4'b1010: return n == v;
      4'b1011: return n != v;
      4'b1100: return ~z & (n == v);
      4'b1101: return z | (n != v);
      4'b1110: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic [3:0] flags_q [NUM_CTX];
  logic [3:0] flags_d [NUM_CTX];
  logic       valid_q, valid_d;
  logic       cond_ex_q, cond_ex_d;
  logic       pcs_q, pcs_d;
  logic       reg_w_q, reg_w_d;
  logic       mem_w_q, mem_w_d;
  logic       undef_q, undef_d;

  logic       ctx_ok;
  logic [3:0] cur_flags;
  logic       pass;
  logic       undef;
  logic       accept;

  // Flags are read straight from the bank, so an update at one edge is seen by the next instruction.
  always_comb begin
    ctx_ok    = int'(ctx) < NUM_CTX;
    cur_flags = 4'b0000;
    if (ctx_ok) cur_flags = flags_q[ctx];
    pass      = ctx_ok & cond_pass(cond, cur_flags);
    undef     = ~ctx_ok | (cond == 4'b1111);
    accept    = valid_in & ~stall & ~flush;
  end

  assign flags_out = cur_flags;

  always_comb begin
    valid_d   = valid_q;
    cond_ex_d = cond_ex_q;
    pcs_d     = pcs_q;
    reg_w_d   = reg_w_q;
    mem_w_d   = mem_w_q;
    undef_d   = undef_q;
    if (flush) begin
      valid_d   = 1'b0;
      cond_ex_d = 1'b0;
      pcs_d     = 1'b0;
      reg_w_d   = 1'b0;
      mem_w_d   = 1'b0;
      undef_d   = 1'b0;
    end else if (!stall) begin
      valid_d   = valid_in;
      cond_ex_d = valid_in & pass;
      pcs_d     = valid_in & pcs_in & pass;
      reg_w_d   = valid_in & reg_w_in & pass & ~no_write_in;
      mem_w_d   = valid_in & mem_w_in & pass;
      undef_d   = valid_in & undef;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CTX; i++) begin
      flags_d[i] = flags_q[i];
      if (accept && pass && (int'(ctx) == i)) begin
        if (flag_write[1]) begin
          flags_d[i][3] = alu_flags[3];
          flags_d[i][1] = alu_flags[1];
        end
        if (flag_write[0]) begin
          flags_d[i][2] = alu_flags[2];
          flags_d[i][0] = alu_flags[0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CTX; i++) flags_q[i] <= 4'b0000;
      valid_q   <= 1'b0;
      cond_ex_q <= 1'b0;
      pcs_q     <= 1'b0;
      reg_w_q   <= 1'b0;
      mem_w_q   <= 1'b0;
      undef_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CTX; i++) flags_q[i] <= flags_d[i];
      valid_q   <= valid_d;
      cond_ex_q <= cond_ex_d;
      pcs_q     <= pcs_d;
      reg_w_q   <= reg_w_d;
      mem_w_q   <= mem_w_d;
      undef_q   <= undef_d;
    end
  end

  assign valid_out  = valid_q;
  assign cond_ex    = cond_ex_q;
  assign pcs_out    = pcs_q;
  assign reg_w_out  = reg_w_q;
  assign mem_w_out  = mem_w_q;
  assign undef_cond = undef_q;

`ifdef COND_SKIP_COUNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  logic [CNT_W-1:0] skip_q, skip_d;

  always_comb begin
    skip_d = skip_q;
    if (accept && !pass) skip_d = sat_inc(skip_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) skip_q <= '0;
    else       skip_q <= skip_d;
  end

  assign skip_cnt = skip_q;
`else
  assign skip_cnt = '0;
`endif

endmodule

// File: tb/tb_cond_logic_pipe.sv
// Directed bench for cond_logic_pipe: vector table plus stall/flush, out-of-range context and reset sequences.
module tb_cond_logic_pipe;

  logic       clk, reset;
  logic       valid_in, stall, flush, ctx, ctx_hi;
  logic [3:0] cond, alu_flags;
  logic [1:0] flag_write;
  logic       pcs_in, reg_w_in, mem_w_in, no_write_in;

  logic        valid_out, cond_ex, pcs_out, reg_w_out, mem_w_out, undef_cond;
  logic [3:0]  flags_out;
  logic [15:0] skip_cnt;

  logic        valid2, cond_ex2, pcs2, reg_w2, mem_w2, undef2;
  logic [3:0]  flags2;
  logic [1:0]  skip2;
  logic [1:0]  ctx2;

  assign ctx2 = {ctx_hi, ctx};

  cond_logic_pipe u_dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .stall(stall), .flush(flush),
    .ctx(ctx), .cond(cond), .alu_flags(alu_flags), .flag_write(flag_write),
    .pcs_in(pcs_in), .reg_w_in(reg_w_in), .mem_w_in(mem_w_in), .no_write_in(no_write_in),
    .valid_out(valid_out), .cond_ex(cond_ex), .pcs_out(pcs_out), .reg_w_out(reg_w_out),
    .mem_w_out(mem_w_out), .undef_cond(undef_cond), .flags_out(flags_out), .skip_cnt(skip_cnt)
  );

  // Three contexts and a 2-bit counter: exercises out-of-range ctx and counter saturation.
  cond_logic_pipe #(.NUM_CTX(3), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .stall(stall), .flush(flush),
    .ctx(ctx2), .cond(cond), .alu_flags(alu_flags), .flag_write(flag_write),
    .pcs_in(pcs_in), .reg_w_in(reg_w_in), .mem_w_in(mem_w_in), .no_write_in(no_write_in),
    .valid_out(valid2), .cond_ex(cond_ex2), .pcs_out(pcs2), .reg_w_out(reg_w2),
    .mem_w_out(mem_w2), .undef_cond(undef2), .flags_out(flags2), .skip_cnt(skip2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // vsf={valid,stall,flush}, ctl={pcs,reg_w,mem_w,no_write}, ex={valid,cond_ex,pcs,reg_w,mem_w,undef}
  typedef struct {
    logic [2:0] vsf;
    logic       c;
    logic [3:0] cnd;
    logic [3:0] af;
    logic [1:0] fw;
    logic [3:0] ctl;
    logic [5:0] ex;
    logic [3:0] efo;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int nfail = 0;

  function automatic logic [15:0] skip_exp(input int n, input int w);
`ifdef COND_SKIP_COUNT_EN
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? 16'(mx) : 16'(n);
`else
    return 16'd0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    {valid_in, stall, flush} = t.vsf;
    ctx        = t.c;
    cond       = t.cnd;
    alu_flags  = t.af;
    flag_write = t.fw;
    {pcs_in, reg_w_in, mem_w_in, no_write_in} = t.ctl;
  endtask

  task automatic step(input vec_t t, input string tag);
    apply(t);
    @(posedge clk);
    #1;
    if (t.vsf == 3'b100 && !t.ex[4]) nfail++;
    chk({tag, " valid_out"},  16'(valid_out),  16'(t.ex[5]));
    chk({tag, " cond_ex"},    16'(cond_ex),    16'(t.ex[4]));
    chk({tag, " pcs_out"},    16'(pcs_out),    16'(t.ex[3]));
    chk({tag, " reg_w_out"},  16'(reg_w_out),  16'(t.ex[2]));
    chk({tag, " mem_w_out"},  16'(mem_w_out),  16'(t.ex[1]));
    chk({tag, " undef_cond"}, 16'(undef_cond), 16'(t.ex[0]));
    chk({tag, " flags_out"},  16'(flags_out),  16'(t.efo));
    chk({tag, " skip_cnt"},   skip_cnt,        skip_exp(nfail, 16));
    chk({tag, " skip_cnt_w2"}, 16'(skip2),     skip_exp(nfail, 2));
  endtask

  vec_t tbl[$];

  initial begin
    tbl.push_back('{3'b100, 1'b0, 4'b0000, 4'b0000, 2'b00, 4'b1110, 6'b100000, 4'b0000});
    tbl.push_back('{3'b100, 1'b1, 4'b1110, 4'b1000, 2'b11, 4'b0100, 6'b110100, 4'b1000});
    tbl.push_back('{3'b100, 1'b1, 4'b0000, 4'b0000, 2'b00, 4'b1000, 6'b111000, 4'b1000});
    tbl.push_back('{3'b100, 1'b0, 4'b0000, 4'b0000, 2'b00, 4'b0010, 6'b100000, 4'b0000});
    tbl.push_back('{3'b100, 1'b0, 4'b1110, 4'b0111, 2'b10, 4'b0000, 6'b110000, 4'b0010});
    tbl.push_back('{3'b100, 1'b0, 4'b1011, 4'b0000, 2'b00, 4'b0010, 6'b110010, 4'b0010});
    tbl.push_back('{3'b100, 1'b0, 4'b1010, 4'b0000, 2'b00, 4'b1110, 6'b100000, 4'b0010});
    tbl.push_back('{3'b100, 1'b0, 4'b1101, 4'b0000, 2'b00, 4'b0101, 6'b110000, 4'b0010});
    tbl.push_back('{3'b100, 1'b0, 4'b1110, 4'b1101, 2'b01, 4'b0000, 6'b110000, 4'b0111});
    tbl.push_back('{3'b100, 1'b0, 4'b1010, 4'b0000, 2'b00, 4'b0100, 6'b110100, 4'b0111});
    tbl.push_back('{3'b100, 1'b0, 4'b1000, 4'b0000, 2'b00, 4'b1000, 6'b111000, 4'b0111});
    tbl.push_back('{3'b100, 1'b0, 4'b1001, 4'b0000, 2'b00, 4'b0100, 6'b100000, 4'b0111});
    tbl.push_back('{3'b100, 1'b0, 4'b1111, 4'b0000, 2'b00, 4'b1110, 6'b100001, 4'b0111});
    tbl.push_back('{3'b000, 1'b0, 4'b1110, 4'b0000, 2'b00, 4'b0100, 6'b000000, 4'b0111});
    tbl.push_back('{3'b101, 1'b0, 4'b1110, 4'b0000, 2'b11, 4'b1110, 6'b000000, 4'b0111});
    tbl.push_back('{3'b100, 1'b0, 4'b1100, 4'b0000, 2'b00, 4'b0010, 6'b110010, 4'b0111});
    tbl.push_back('{3'b100, 1'b0, 4'b0010, 4'b0000, 2'b00, 4'b0100, 6'b110100, 4'b0111});
    tbl.push_back('{3'b100, 1'b0, 4'b0111, 4'b0000, 2'b00, 4'b0000, 6'b100000, 4'b0111});
    tbl.push_back('{3'b100, 1'b0, 4'b0100, 4'b0000, 2'b00, 4'b0000, 6'b110000, 4'b0111});
    tbl.push_back('{3'b100, 1'b0, 4'b0110, 4'b0000, 2'b00, 4'b0000, 6'b110000, 4'b0111});
    tbl.push_back('{3'b100, 1'b0, 4'b0011, 4'b0000, 2'b00, 4'b0000, 6'b100000, 4'b0111});
    tbl.push_back('{3'b100, 1'b0, 4'b0101, 4'b0000, 2'b00, 4'b0000, 6'b100000, 4'b0111});
    tbl.push_back('{3'b100, 1'b0, 4'b0001, 4'b0000, 2'b00, 4'b0000, 6'b110000, 4'b0111});
    tbl.push_back('{3'b100, 1'b1, 4'b0001, 4'b0000, 2'b00, 4'b0000, 6'b100000, 4'b1000});
    tbl.push_back('{3'b100, 1'b1, 4'b0001, 4'b0000, 2'b11, 4'b0000, 6'b100000, 4'b1000});

    reset = 1'b1;
    ctx_hi = 1'b0;
    apply('{3'b000, 1'b0, 4'b0000, 4'b0000, 2'b00, 4'b0000, 6'b000000, 4'b0000});
    #1;
    chk("reset valid_out", 16'(valid_out), 16'd0);
    chk("reset flags_out", 16'(flags_out), 16'd0);
    chk("reset skip_cnt",  skip_cnt,       16'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    // Stall three cycles with a live instruction, then flush while still stalled.
    step('{3'b100, 1'b0, 4'b1110, 4'b0000, 2'b00, 4'b0100, 6'b110100, 4'b0111}, "pre_stall");
    for (int i = 0; i < 3; i++)
      step('{3'b110, 1'b0, 4'b0000, 4'b0000, 2'b11, 4'b0100, 6'b110100, 4'b0111}, $sformatf("stall%0d", i));
    step('{3'b111, 1'b0, 4'b1110, 4'b0000, 2'b11, 4'b0100, 6'b000000, 4'b0111}, "stall_flush");

    // Context 3 does not exist in the three-context instance.
    apply('{3'b100, 1'b1, 4'b1110, 4'b1111, 2'b11, 4'b1110, 6'b000000, 4'b0000});
    ctx_hi = 1'b1;
    @(posedge clk);
    #1;
    chk("oor valid_out",  16'(valid2), 16'd1);
    chk("oor cond_ex",    16'(cond_ex2), 16'd0);
    chk("oor undef_cond", 16'(undef2), 16'd1);
    chk("oor pcs_out",    16'(pcs2), 16'd0);
    chk("oor reg_w_out",  16'(reg_w2), 16'd0);
    chk("oor flags_out",  16'(flags2), 16'd0);
    chk("oor skip_cnt",   16'(skip2), skip_exp(nfail + 1, 2));
    ctx_hi = 1'b0;
    ctx = 1'b1;
    #1;
    chk("oor ctx1 flags", 16'(flags2), 16'h8);
    ctx = 1'b0;
    #1;
    chk("oor ctx0 flags", 16'(flags2), 16'h7);

    // Asynchronous reset while an instruction is visible at the outputs.
    apply('{3'b100, 1'b0, 4'b1110, 4'b0000, 2'b00, 4'b1110, 6'b000000, 4'b0000});
    @(posedge clk);
    #1;
    chk("prereset valid_out", 16'(valid_out), 16'd1);
    reset = 1'b1;
    #1;
    chk("async valid_out", 16'(valid_out), 16'd0);
    chk("async cond_ex",   16'(cond_ex), 16'd0);
    chk("async reg_w_out", 16'(reg_w_out), 16'd0);
    chk("async pcs_out",   16'(pcs_out), 16'd0);
    chk("async ctx0 flags", 16'(flags_out), 16'd0);
    chk("async skip_cnt",  skip_cnt, 16'd0);
    ctx = 1'b1;
    #1;
    chk("async ctx1 flags", 16'(flags_out), 16'd0);
    chk("async ctx1 flags w2", 16'(flags2), 16'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post reset valid_out", 16'(valid_out), 16'd0);
    nfail = 0;
    step(tbl[0], "post_reset_eq");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
